pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register that replaces the fixed-field, always-advancing stage registers (F/D, D/E, E/M, M/W) of the 5-stage MIPS core. It carries NCH payload channels of WIDTH bits each, for example pc, instr, ALU result and read data. It adds a valid/ready handshake, synchronous flush (bubble insertion) and a saturating stall counter. An optional 2-entry skid buffer breaks the combinational ready path between stages.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stall_ctr.sv | 22 ++
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the parametrised inter-stage pipeline register.
// Holds the occupancy state encoding, the nop fill word and default parameters.
// Optional skid mode is selected per build with macro PIPE_STAGE_SKID_EN.
package pipe_pkg;

  // Occupancy of a stage: EMPTY, one word in the main register, or main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Base mode only has two states; FULL is the same encoding as ONE.
  localparam state_t FULL = ONE;

  // All-zero instruction word decodes as a nop, so bubbles carry zeros.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 4;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/pipe_stall_ctr.sv
// Saturating event counter used to count output stall cycles.
// Latency: count updates on the clock edge after inc is seen.
// Backpressure: none; counts every enabled cycle and holds at all-ones.
// Ports: clk, reset (async, active-low), inc (count enable), cnt (current count).
module pipe_stall_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: NCH channels of WIDTH bits, valid/ready, flush, stall count.
// Latency: 1 cycle from input fire to out_valid/out_data; full throughput with out_ready=1.
// Backpressure: base in_ready = !out_valid || out_ready; PIPE_STAGE_SKID_EN adds a skid slot and registered in_ready.
// Ports: clk, reset (async active-low), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, stall_cnt (saturating out_valid && !out_ready cycles).
// Build option: define PIPE_STAGE_SKID_EN for the 2-entry skid-buffer variant.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int DW = NCH * WIDTH;
  localparam logic [WIDTH-1:0] NOP_CH = WIDTH'(NOP_WORD);
  localparam logic [DW-1:0] NOP_PAYLOAD = {NCH{NOP_CH}};

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic          in_fire, out_fire;
  logic          stall_inc;

`ifdef PIPE_STAGE_SKID_EN
  logic [DW-1:0] skid_q, skid_d;
  logic          ready_q;

  // Registered ready: no combinational path from out_ready to in_ready.
  assign in_ready = ready_q;
`else
  assign in_ready = (state_q == EMPTY) || out_ready;
`endif

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign stall_inc = out_valid && !out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      // Bubble wins over any input fire in the same cycle.
      state_d = EMPTY;
      main_d  = NOP_PAYLOAD;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = NOP_PAYLOAD;
`endif
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // Downstream stalled: park the new word behind main.
            skid_d  = in_data;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
`else
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = FULL;
          end
        end
        default: begin
          // In FULL an input fire implies an output fire (in_ready = out_ready).
          if (out_fire) begin
            if (in_fire) begin
              main_d = in_data;
            end else begin
              state_d = EMPTY;
            end
          end
        end
      endcase
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_PAYLOAD;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= NOP_PAYLOAD;
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
      ready_q <= (state_d != TWO);
`endif
    end
  end

  pipe_stall_ctr #(
    .CNT_W(CNT_W)
  ) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a scoreboard of accepted payloads.
// Main instance uses default parameters; a small instance with CNT_W=4 covers saturation.
// Works for both the base build and the PIPE_STAGE_SKID_EN build.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  stall_cnt;

  logic         s_in_valid;
  logic         s_in_ready;
  logic [15:0]  s_in_data;
  logic         s_out_valid;
  logic         s_out_ready;
  logic [15:0]  s_out_data;
  logic [3:0]   s_stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [127:0] sb[$];

  pipe_stage_reg #(.WIDTH(32), .NCH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.WIDTH(8), .NCH(2), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] ch0, input logic [31:0] ch1);
    return {~ch1, ~ch0, ch1, ch0};
  endfunction

  // Advance one clock; inputs are driven and registered outputs read 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: fires are sampled mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL sb_underflow observed=%h expected=none", out_data);
        end
        if (sb.size() > 0) chk("sb_order", out_data, sb.pop_front());
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_data = {4{32'hA5A5_A5A5}};
    s_in_valid = 1'b0; s_in_data = 16'h0000; s_out_ready = 1'b0;

    // Reset held with valid input present.
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_stall_cnt", 128'(stall_cnt), 128'h0);
    @(posedge clk); #2;
    reset = 1'b1;
    tick();
    chk("rel_out_valid", 128'(out_valid), 128'(1'b1));
    chk("rel_ch0", 128'(out_data[31:0]), 128'(32'hA5A5_A5A5));
    in_valid = 1'b0;

    // Streaming: one word per cycle, each visible one cycle after its fire.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = mk(32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
      tick();
      chk("stream_valid", 128'(out_valid), 128'(1'b1));
      chk("stream_ch0", 128'(out_data[31:0]), 128'(32'h3000 + 32'(4 * i)));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 128'(out_valid), 128'(1'b0));

    // Backpressure.
    in_valid = 1'b1; in_data = mk(32'h3000, 32'h2222_0000);
    tick();
    in_data = mk(32'h3004, 32'h2222_0004);
    out_ready = 1'b0;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("skid_ready_before", 128'(in_ready), 128'(1'b1));
`else
    chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", 128'(out_data[31:0]), 128'(32'h3000));
      chk("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
`ifdef PIPE_STAGE_SKID_EN
      in_valid = 1'b0;
`endif
    end
    chk("bp_stall_cnt", 128'(stall_cnt), 128'd5);
    out_ready = 1'b1;
    tick();
    chk("bp_second_valid", 128'(out_valid), 128'(1'b1));
    chk("bp_second_ch0", 128'(out_data[31:0]), 128'(32'h3004));
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 128'(out_valid), 128'(1'b0));

    // Flush with a colliding input fire.
    in_valid = 1'b1; in_data = mk(32'h1111, 32'h0);
    tick();
    flush = 1'b1; in_data = mk(32'h4000, 32'h8C01_0004);
    tick();
    chk("flush_valid", 128'(out_valid), 128'(1'b0));
    chk("flush_data", out_data, 128'h0);
    chk("flush_stall", 128'(stall_cnt), 128'd5);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_dropped", 128'(out_valid), 128'(1'b0));

    // Async reset while holding stalled data.
    in_valid = 1'b1; in_data = mk(32'h5000, 32'h0);
    tick();
    in_data = mk(32'h5004, 32'h0); out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    chk("two_in_ready", 128'(in_ready), 128'(1'b0));
`endif
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(1'b0));
    chk("arst_data", out_data, 128'h0);
    chk("arst_stall", 128'(stall_cnt), 128'h0);
    #4 reset = 1'b1;
    #1;
    chk("arst_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1;
    tick();
    chk("arst_empty", 128'(out_valid), 128'(1'b0));
    in_valid = 1'b1; in_data = mk(32'h6000, 32'h0);
    tick();
    chk("arst_next_ch0", 128'(out_data[31:0]), 128'(32'h6000));
    in_valid = 1'b0;
    tick();
    chk("arst_drained", 128'(out_valid), 128'(1'b0));

    // Saturation on the CNT_W=4 instance.
    s_in_valid = 1'b1; s_in_data = 16'hBEEF;
    tick();
    s_in_valid = 1'b0;
    repeat (14) tick();
    chk("sat_pre", 128'(s_stall_cnt), 128'd14);
    repeat (6) tick();
    chk("sat_max", 128'(s_stall_cnt), 128'd15);
    chk("sat_data", 128'(s_out_data), 128'(16'hBEEF));
    repeat (3) tick();
    chk("sat_hold", 128'(s_stall_cnt), 128'd15);

    chk("sb_empty", 128'(sb.size()), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
